data_mem_ctrl: RTL and testbench

Parametrised, byte-addressable data memory for the MIPS datapath. It supports byte, halfword and word loads and stores with sign/zero extension, a valid/ready request port and a registered response. Misaligned, out-of-range and illegal accesses are flagged as faults. On reset, a sequencer clears the array one word per cycle instead of clearing it in a single cycle. It sits between the load/store unit and the memory array, replacing the single-cycle word-only memory.

---
 rtl/data_mem_if.sv | 41 ++++
 rtl/data_mem_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_if
// Description : Request/response bundle between the load/store unit and
//               data_mem_ctrl.
//               master = load/store unit, slave = memory controller.
//   req_valid/req_ready : request handshake (accept on valid && ready)
//   req_we              : 1 = store, 0 = load
//   req_size            : 0 byte, 1 halfword, 2 word, 3 illegal
//   req_unsigned        : load zero-extends when 1
//   req_addr            : byte address
//   req_wdata           : right-justified store data
//   rsp_valid           : one-cycle pulse per accepted request
//   rsp_rdata/rsp_fault : load result / fault flag, valid with rsp_valid
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_fault;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Byte-addressable data memory with byte/halfword/word loads
//               and stores, sign/zero extension, registered response, fault
//               detection and a one-word-per-cycle clear sequencer on reset.
//   CLK        : clock, rising edge
//   RST        : asynchronous active-low reset
//   bus        : data_mem_if slave (request/response)
//   init_busy  : clear sequencer running
//   test_value : bits [15:0] of word TEST_WORD (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int DEPTH          = 100,
  parameter int ADDR_WIDTH     = 32,
  parameter int TEST_WORD      = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic         CLK,
  input  logic         RST,
  data_mem_if.slave    bus,
  output logic         init_busy,
  output logic [15:0]  test_value
);

  localparam int                    c_iw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_iw-1:0]       c_last  = c_iw'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-3:0] c_depth = (ADDR_WIDTH-2)'(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_iw-1:0]   r_clear_ptr, w_clear_ptr_nxt;
  logic              w_clear_we;

  logic [31:0]       r_mem [DEPTH];

  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_fault;

  logic [ADDR_WIDTH-3:0] w_idx_full;
  logic [c_iw-1:0]   w_idx;
  logic [1:0]        w_lane;
  logic              w_oob;
  logic              w_fault;
  logic              w_ready;
  logic              w_accept;
  logic              w_store;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rword;
  logic [7:0]        w_rbyte;
  logic [15:0]       w_rhalf;
  logic [31:0]       w_load;

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      r_clear_ptr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_clear_ptr <= w_clear_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_clear_ptr_nxt = r_clear_ptr;
    w_clear_we      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clear_we      = 1'b1;
        w_clear_ptr_nxt = r_clear_ptr + 1'b1;
        if (r_clear_ptr == c_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Reset is folded in so a RUN-after-reset configuration never advertises
  // ready while RST is still held low.
  assign w_ready   = (r_state == ST_RUN) & RST;
  assign init_busy = (r_state == ST_CLEAR);

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign w_idx_full = bus.req_addr[ADDR_WIDTH-1:2];
  assign w_idx      = w_idx_full[c_iw-1:0];
  assign w_lane     = bus.req_addr[1:0];
  assign w_oob      = (w_idx_full >= c_depth);
  assign w_accept   = bus.req_valid & w_ready;
  assign w_store    = w_accept & bus.req_we & ~w_fault;

  always_comb begin
    w_fault = 1'b1;
    w_be    = 4'b0000;
    w_wdata = bus.req_wdata;
    case (bus.req_size)
      2'd0: begin
        w_fault = w_oob;
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        w_fault = w_oob | w_lane[0];
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.req_wdata[15:0]}};
      end
      2'd2: begin
        w_fault = w_oob | (w_lane != 2'd0);
        w_be    = 4'b1111;
      end
      default: begin
        w_fault = 1'b1;
      end
    endcase
  end

  // Out-of-range indices are always faults, so their read data is discarded.
  assign w_rword = r_mem[w_idx];
  assign w_rbyte = w_rword[{w_lane, 3'b000} +: 8];
  assign w_rhalf = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_load = w_rword;
    case (bus.req_size)
      2'd0:    w_load = bus.req_unsigned ? {24'd0, w_rbyte}
                                         : {{24{w_rbyte[7]}}, w_rbyte};
      2'd1:    w_load = bus.req_unsigned ? {16'd0, w_rhalf}
                                         : {{16{w_rhalf[15]}}, w_rhalf};
      default: w_load = w_rword;
    endcase
  end

  // --------------------------------------------------------------------------
  // Array: clear writes take priority; no requests are accepted during CLEAR
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_clear_we) begin
      r_mem[r_clear_ptr] <= '0;
    end else if (w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  assign test_value = r_mem[TEST_WORD][15:0];

  // --------------------------------------------------------------------------
  // Registered response; data and fault hold when nothing is accepted
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_fault <= w_fault;
        r_rsp_rdata <= (bus.req_we | w_fault) ? 32'd0 : w_load;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_fault = r_rsp_fault;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Self-checking bench for data_mem_ctrl. A byte-array model
//               computes expected load data, faults and test_value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam int DEPTH      = 100;
  localparam int ADDR_WIDTH = 32;
  localparam int TEST_WORD  = 0;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        init_busy;
  logic [15:0] test_value;

  data_mem_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  data_mem_ctrl #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH),
    .TEST_WORD(TEST_WORD), .CLEAR_ON_RESET(1)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus.slave),
    .init_busy(init_busy), .test_value(test_value)
  );

  always #5 CLK = ~CLK;

  logic [7:0]  mb [DEPTH*4];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_rdata = '0;
  logic        last_fault = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
  endfunction

  function automatic logic [15:0] model_tv();
    return {mb[TEST_WORD*4+1], mb[TEST_WORD*4]};
  endfunction

  // Spec-level model: a request of n bytes at addr, little-endian.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic flt, output logic [31:0] rd);
    int n;
    logic [31:0] v;
    n   = 1 << size;
    flt = (size == 2'd3) || ((addr % n) != 0) || ((addr / 4) >= DEPTH);
    rd  = '0;
    if (flt) return;
    if (we) begin
      for (int k = 0; k < n; k++) mb[int'(addr) + k] = 8'(wdata >> (8*k));
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v = v | (32'(mb[int'(addr) + k]) << (8*k));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endfunction

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic        ef;
    logic [31:0] ed;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge CLK); #1;
    model(we, size, uns, addr, wdata, ef, ed);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_fault", 32'(bus.rsp_fault), 32'(ef));
    chk("rsp_rdata", bus.rsp_rdata, ed);
    chk("test_value", 32'(test_value), 32'(model_tv()));
    last_rdata = ed;
    last_fault = ef;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    @(posedge CLK); #1;
    chk("idle_valid", 32'(bus.rsp_valid), 32'd0);
    chk("idle_rdata_hold", bus.rsp_rdata, last_rdata);
    chk("idle_fault_hold", 32'(bus.rsp_fault), 32'(last_fault));
  endtask

  // Called right after RST rises; counts cycles with init_busy high.
  task automatic wait_clear();
    int cnt;
    cnt = 0;
    while (init_busy && cnt < 1000) begin
      if (bus.req_ready !== 1'b0) begin
        chk("ready_in_clear", 32'(bus.req_ready), 32'd0);
      end
      @(posedge CLK); #1;
      cnt++;
      if (cnt == 1) chk("tv_after_first_clear", 32'(test_value), 32'd0);
    end
    chk("clear_cycles", 32'(cnt), 32'(DEPTH));
    chk("ready_after_clear", 32'(bus.req_ready), 32'd1);
    model_clear();
    last_rdata = '0;
    last_fault = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // Reset state
    #23;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_fault", 32'(bus.rsp_fault), 32'd0);
    chk("rst_busy", 32'(init_busy), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1;
    wait_clear();
    chk("tv_zero", 32'(test_value), 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    chk("lw0_zero", bus.rsp_rdata, 32'h0);

    // Sub-word merge and extension
    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 32'h9, 32'h000000AB);
    issue(1'b1, 2'd1, 1'b0, 32'hA, 32'h0000BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    chk("merge", bus.rsp_rdata, 32'hBEEFAB44);
    issue(1'b0, 2'd0, 1'b0, 32'h9, 32'h0);
    chk("lb", bus.rsp_rdata, 32'hFFFFFFAB);
    issue(1'b0, 2'd0, 1'b1, 32'h9, 32'h0);
    chk("lbu", bus.rsp_rdata, 32'h000000AB);
    issue(1'b0, 2'd1, 1'b0, 32'hA, 32'h0);
    chk("lh", bus.rsp_rdata, 32'hFFFFBEEF);
    issue(1'b0, 2'd1, 1'b1, 32'hA, 32'h0);
    chk("lhu", bus.rsp_rdata, 32'h0000BEEF);
    idle();

    // Faults
    issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h3, 32'h1234);
    issue(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'(DEPTH*4), 32'hDEADBEEF);
    chk("fault_oob", 32'(bus.rsp_fault), 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    chk("post_fault", bus.rsp_rdata, 32'hBEEFAB44);

    // Back-to-back
    issue(1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D);
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    chk("b2b_data", bus.rsp_rdata, 32'hCAFEF00D);
    chk("b2b_tv", 32'(test_value), 32'h0000F00D);
    idle();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        s = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = $urandom;
        else a = 32'($urandom_range(0, DEPTH*4 + 15));
        issue(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    // Reset mid-operation
    issue(1'b1, 2'd2, 1'b0, 32'h0, 32'h5A5A1234);
    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'h87654321);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h8;
    #2 RST = 1'b0;
    #7;
    chk("midrst_valid0", 32'(bus.rsp_valid), 32'd0);
    @(posedge CLK); #1;
    chk("midrst_valid1", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_busy", 32'(init_busy), 32'd1);
    bus.req_valid = 1'b0;
    RST = 1'b1;
    wait_clear();
    issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    chk("midrst_cleared", bus.rsp_rdata, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
